// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the ID-stage hazard unit: forwarding encodings,
// memory-wait FSM states and the scoreboard entry layout.
package pipeline_pkg;

    localparam int unsigned REG_AW     = 5;
    // Scoreboard addresses are stored zero-extended so one entry type serves any REG_AW up to this.
    localparam int unsigned REG_AW_MAX = 8;

    typedef enum logic [1:0] {
        FWD_REG      = 2'd0,
        FWD_EX_ALU   = 2'd1,
        FWD_MEM_ALU  = 2'd2,
        FWD_MEM_LOAD = 2'd3
    } fwd_sel_e;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] addr;
        logic                  is_load;
        logic                  is_mem;
    } sb_entry_t;

    function automatic logic sb_match(
        input sb_entry_t             e,
        input logic [REG_AW_MAX-1:0] src,
        input logic                  use_src
    );
        return e.valid && (e.addr == src) && (e.addr != '0) && use_src;
    endfunction

    function automatic fwd_sel_e pick_fwd(
        input logic      m_ex,
        input logic      m_mem,
        input sb_entry_t ex,
        input sb_entry_t mem
    );
        if (m_ex && !ex.is_load) begin
            return FWD_EX_ALU;
        end
        if (m_mem) begin
            return mem.is_load ? FWD_MEM_LOAD : FWD_MEM_ALU;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// ID-stage hazard interface: the pipeline (master) presents the decoded
// instruction and memory status, the hazard unit (slave) returns control.
interface pipeline_hazard_unit_if #(
    parameter int unsigned REG_AW = pipeline_pkg::REG_AW,
    parameter int unsigned CNT_W  = 16
);

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wr_en;
    logic [REG_AW-1:0] id_wr_addr;
    logic              id_is_load;
    logic              id_is_mem;
    logic              id_is_branch;
    logic              id_branch_taken;
    logic              mio_ready;

    logic              stall_if;
    logic              bubble_ex;
    logic              flush_if;
    logic              freeze;
    logic [1:0]        fwd_rs_sel;
    logic [1:0]        fwd_rt_sel;
    logic              mem_timeout;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_addr,
               id_is_load, id_is_mem, id_is_branch, id_branch_taken, mio_ready,
        input  stall_if, bubble_ex, flush_if, freeze, fwd_rs_sel, fwd_rt_sel,
               mem_timeout, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_wr_addr,
               id_is_load, id_is_mem, id_is_branch, id_branch_taken, mio_ready,
        output stall_if, bubble_ex, flush_if, freeze, fwd_rs_sel, fwd_rt_sel,
               mem_timeout, stall_count
    );

endinterface

// File: rtl/pipeline_hazard_unit_scoreboard.sv
// DEPTH-entry shift register of in-flight register writes (0=EX, 1=MEM, 2..=WB+)
// with per-entry source-match flags for rs and rt.
module hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold_i,
    input  logic                  ins_valid_i,
    input  logic [REG_AW-1:0]     ins_addr_i,
    input  logic                  ins_is_load_i,
    input  logic                  ins_is_mem_i,
    input  logic [REG_AW-1:0]     rs_i,
    input  logic [REG_AW-1:0]     rt_i,
    input  logic                  use_rs_i,
    input  logic                  use_rt_i,
    output sb_entry_t [DEPTH-1:0] entry_o,
    output logic [DEPTH-1:0]      match_rs_o,
    output logic [DEPTH-1:0]      match_rt_o
);

    sb_entry_t [DEPTH-1:0] entry_q, entry_d;
    logic [REG_AW_MAX-1:0] rs_ext, rt_ext;

    assign rs_ext = REG_AW_MAX'(rs_i);
    assign rt_ext = REG_AW_MAX'(rt_i);

    always_comb begin
        entry_d = entry_q;
        if (!hold_i) begin
            entry_d[0] = '{
                valid:   ins_valid_i,
                addr:    ins_valid_i ? REG_AW_MAX'(ins_addr_i) : '0,
                is_load: ins_valid_i & ins_is_load_i,
                is_mem:  ins_valid_i & ins_is_mem_i
            };
            for (int unsigned i = 1; i < DEPTH; i++) begin
                entry_d[i] = entry_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    always_comb begin
        match_rs_o = '0;
        match_rt_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match_rs_o[i] = sb_match(entry_q[i], rs_ext, use_rs_i);
            match_rt_o[i] = sb_match(entry_q[i], rt_ext, use_rt_i);
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// ID-stage hazard unit: forwarding selects, load-use/branch stalls, branch
// flushes, memory-wait freeze with timeout, and a stall performance counter.
module pipeline_hazard_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_AW       = pipeline_pkg::REG_AW,
    parameter int unsigned DEPTH        = 3,
    parameter int unsigned FWD_EN       = 1,
    parameter int unsigned WAIT_TIMEOUT = 255,
    parameter int unsigned CNT_W        = 16
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_unit_if.slave hz
);

    localparam int unsigned WCW = $clog2(WAIT_TIMEOUT + 1);

    sb_entry_t [DEPTH-1:0] sb;
    logic [DEPTH-1:0]      m_rs, m_rt;
    logic                  hazard, freeze_w, stall_w, stall_if_w, ins_valid;
    fwd_sel_e              fwd_rs, fwd_rt;

    hz_state_e             state_q, state_d;
    logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
    logic                  mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic                  unused_sb;

    hazard_scoreboard #(
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
    ) u_sb (
        .clk           (clk),
        .rst           (rst),
        .hold_i        (freeze_w),
        .ins_valid_i   (ins_valid),
        .ins_addr_i    (hz.id_wr_addr),
        .ins_is_load_i (hz.id_is_load),
        .ins_is_mem_i  (hz.id_is_mem),
        .rs_i          (hz.id_rs),
        .rt_i          (hz.id_rt),
        .use_rs_i      (hz.id_use_rs),
        .use_rt_i      (hz.id_use_rt),
        .entry_o       (sb),
        .match_rs_o    (m_rs),
        .match_rt_o    (m_rt)
    );

    // Older entries only matter in stall-only mode; this sink keeps them visibly consumed.
    assign unused_sb = ^{sb, m_rs, m_rt};

    assign freeze_w = sb[1].valid & sb[1].is_mem & ~hz.mio_ready;

    always_comb begin
        hazard = 1'b0;
        if (FWD_EN != 0) begin
            hazard = (sb[0].is_load && (m_rs[0] || m_rt[0]))
                  || (hz.id_is_branch && (m_rs[0] || m_rt[0]
                                          || (sb[1].is_load && (m_rs[1] || m_rt[1]))));
        end else begin
            hazard = |(m_rs | m_rt);
        end
    end

    // Freeze overrides the stall response; the scoreboard holds instead of bubbling.
    assign stall_w    = hazard & ~freeze_w;
    assign stall_if_w = freeze_w | stall_w;
    assign ins_valid  = hz.id_valid & hz.id_wr_en & ~hazard;

    always_comb begin
        fwd_rs = FWD_REG;
        fwd_rt = FWD_REG;
        if (FWD_EN != 0) begin
            fwd_rs = pick_fwd(m_rs[0], m_rs[1], sb[0], sb[1]);
            fwd_rt = pick_fwd(m_rt[0], m_rt[1], sb[0], sb[1]);
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        stall_cnt_d   = stall_cnt_q;
        case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (freeze_w) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (!freeze_w) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    if (32'(wait_cnt_q) < WAIT_TIMEOUT) begin
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end
                    if (32'(wait_cnt_q) + 32'd1 >= WAIT_TIMEOUT) begin
                        mem_timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
        if (stall_if_w && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign hz.stall_if    = stall_if_w;
    assign hz.bubble_ex   = stall_w;
    assign hz.flush_if    = hz.id_branch_taken & ~hazard & ~freeze_w;
    assign hz.freeze      = freeze_w;
    assign hz.fwd_rs_sel  = fwd_rs;
    assign hz.fwd_rt_sel  = fwd_rt;
    assign hz.mem_timeout = mem_timeout_q;
    assign hz.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench: dut_a forwards (WAIT_TIMEOUT=4), dut_b runs stall-only.
module tb_pipeline_hazard_unit;
    import pipeline_pkg::*;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       wr;
        logic [4:0] wa;
        logic       ld;
        logic       mem;
        logic       br;
        logic       tk;
    } id_t;

    logic clk = 1'b0;
    logic rst;
    id_t  in_a, in_b;
    logic mio_a, mio_b;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_unit_if #(.REG_AW(5), .CNT_W(16)) ifa ();
    pipeline_hazard_unit_if #(.REG_AW(5), .CNT_W(16)) ifb ();

    assign ifa.id_valid = in_a.v;    assign ifb.id_valid = in_b.v;
    assign ifa.id_rs = in_a.rs;      assign ifb.id_rs = in_b.rs;
    assign ifa.id_rt = in_a.rt;      assign ifb.id_rt = in_b.rt;
    assign ifa.id_use_rs = in_a.urs; assign ifb.id_use_rs = in_b.urs;
    assign ifa.id_use_rt = in_a.urt; assign ifb.id_use_rt = in_b.urt;
    assign ifa.id_wr_en = in_a.wr;   assign ifb.id_wr_en = in_b.wr;
    assign ifa.id_wr_addr = in_a.wa; assign ifb.id_wr_addr = in_b.wa;
    assign ifa.id_is_load = in_a.ld; assign ifb.id_is_load = in_b.ld;
    assign ifa.id_is_mem = in_a.mem; assign ifb.id_is_mem = in_b.mem;
    assign ifa.id_is_branch = in_a.br;    assign ifb.id_is_branch = in_b.br;
    assign ifa.id_branch_taken = in_a.tk; assign ifb.id_branch_taken = in_b.tk;
    assign ifa.mio_ready = mio_a;    assign ifb.mio_ready = mio_b;

    pipeline_hazard_unit #(
        .REG_AW(5), .DEPTH(3), .FWD_EN(1), .WAIT_TIMEOUT(4), .CNT_W(16)
    ) dut_a (.clk(clk), .rst(rst), .hz(ifa));

    pipeline_hazard_unit #(
        .REG_AW(5), .DEPTH(3), .FWD_EN(0), .WAIT_TIMEOUT(255), .CNT_W(16)
    ) dut_b (.clk(clk), .rst(rst), .hz(ifb));

    // {stall_if, bubble_ex, flush_if, freeze, fwd_rs_sel, fwd_rt_sel}
    function automatic logic [7:0] obs_a();
        return {ifa.stall_if, ifa.bubble_ex, ifa.flush_if, ifa.freeze, ifa.fwd_rs_sel, ifa.fwd_rt_sel};
    endfunction

    function automatic logic [7:0] obs_b();
        return {ifb.stall_if, ifb.bubble_ex, ifb.flush_if, ifb.freeze, ifb.fwd_rs_sel, ifb.fwd_rt_sel};
    endfunction

    function automatic id_t alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wa);
        return '{v:1'b1, rs:rs, rt:rt, urs:1'b1, urt:1'b1, wr:1'b1, wa:wa, ld:1'b0, mem:1'b0, br:1'b0, tk:1'b0};
    endfunction

    function automatic id_t lw(input logic [4:0] base, input logic [4:0] wa);
        return '{v:1'b1, rs:base, rt:5'd0, urs:1'b1, urt:1'b0, wr:1'b1, wa:wa, ld:1'b1, mem:1'b1, br:1'b0, tk:1'b0};
    endfunction

    function automatic id_t br(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt);
        return '{v:1'b1, rs:rs, rt:rt, urs:1'b1, urt:use_rt, wr:1'b0, wa:5'd0, ld:1'b0, mem:1'b0, br:1'b1, tk:1'b1};
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        in_a  = '0;
        in_b  = '0;
        mio_a = 1'b1;
        mio_b = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        checks++;
        if (obs_a() !== 8'b0) begin failures++; $display("FAIL reset_outs_a got=%b exp=%b", obs_a(), 8'b0); end
        checks++;
        if (obs_b() !== 8'b0) begin failures++; $display("FAIL reset_outs_b got=%b exp=%b", obs_b(), 8'b0); end
        checks++;
        if ({ifa.mem_timeout, ifa.stall_count} !== 17'd0) begin
            failures++; $display("FAIL reset_regs got=%0d/%0d exp=0/0", ifa.mem_timeout, ifa.stall_count);
        end
        checks++;
        if (dut_a.state_q !== ST_RUN) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut_a.state_q, ST_RUN); end
        next();
    endtask

    task automatic test_forwarding();
        do_reset();
        in_a = alu(5'd1, 5'd2, 5'd3);  settle();
        checks++;
        if (obs_a() !== 8'b0000_0000) begin failures++; $display("FAIL fwd_producer got=%b exp=%b", obs_a(), 8'b0000_0000); end
        next();
        in_a = alu(5'd3, 5'd5, 5'd4);  settle();
        checks++;
        if (obs_a() !== 8'b0000_0100) begin failures++; $display("FAIL fwd_ex_alu got=%b exp=%b", obs_a(), 8'b0000_0100); end
        next();
        in_a = alu(5'd3, 5'd7, 5'd6);  settle();
        checks++;
        if (obs_a() !== 8'b0000_1000) begin failures++; $display("FAIL fwd_mem_alu got=%b exp=%b", obs_a(), 8'b0000_1000); end
        next();
        in_a = alu(5'd3, 5'd0, 5'd7);  settle();
        checks++;
        if (obs_a() !== 8'b0000_0000) begin failures++; $display("FAIL fwd_wb_regfile got=%b exp=%b", obs_a(), 8'b0000_0000); end
        next();
    endtask

    task automatic test_load_use();
        do_reset();
        in_a = lw(5'd0, 5'd8);  settle();
        checks++;
        if (obs_a() !== 8'b0000_0000) begin failures++; $display("FAIL lu_load got=%b exp=%b", obs_a(), 8'b0000_0000); end
        next();
        in_a = alu(5'd8, 5'd8, 5'd9);  settle();
        checks++;
        if (obs_a() !== 8'b1100_0000) begin failures++; $display("FAIL lu_stall got=%b exp=%b", obs_a(), 8'b1100_0000); end
        next();
        settle();
        checks++;
        if (obs_a() !== 8'b0000_1111) begin failures++; $display("FAIL lu_fwd_load got=%b exp=%b", obs_a(), 8'b0000_1111); end
        checks++;
        if (ifa.stall_count !== 16'd1) begin failures++; $display("FAIL lu_count got=%0d exp=1", ifa.stall_count); end
        next();
    endtask

    task automatic test_branch();
        do_reset();
        in_a = '{v:1'b1, rs:5'd1, rt:5'd0, urs:1'b1, urt:1'b0, wr:1'b1, wa:5'd8, ld:1'b0, mem:1'b0, br:1'b0, tk:1'b0};
        next();
        in_a = br(5'd8, 5'd0, 1'b1);  settle();
        checks++;
        if (obs_a() !== 8'b1100_0100) begin failures++; $display("FAIL beq_stall got=%b exp=%b", obs_a(), 8'b1100_0100); end
        next();
        settle();
        checks++;
        if (obs_a() !== 8'b0010_1000) begin failures++; $display("FAIL beq_flush got=%b exp=%b", obs_a(), 8'b0010_1000); end
        next();
        do_reset();
        in_a = lw(5'd29, 5'd31);  next();
        in_a = br(5'd31, 5'd0, 1'b0);  settle();
        checks++;
        if (obs_a() !== 8'b1100_0000) begin failures++; $display("FAIL jr_stall1 got=%b exp=%b", obs_a(), 8'b1100_0000); end
        next();
        settle();
        checks++;
        if (obs_a() !== 8'b1100_1100) begin failures++; $display("FAIL jr_stall2 got=%b exp=%b", obs_a(), 8'b1100_1100); end
        next();
        settle();
        checks++;
        if (obs_a() !== 8'b0010_0000) begin failures++; $display("FAIL jr_flush got=%b exp=%b", obs_a(), 8'b0010_0000); end
        checks++;
        if (ifa.stall_count !== 16'd2) begin failures++; $display("FAIL jr_count got=%0d exp=2", ifa.stall_count); end
        next();
    endtask

    task automatic test_reg_zero();
        do_reset();
        in_a = alu(5'd1, 5'd2, 5'd0);  next();
        in_a = alu(5'd0, 5'd0, 5'd5);  settle();
        checks++;
        if (obs_a() !== 8'b0000_0000) begin failures++; $display("FAIL zero_reg got=%b exp=%b", obs_a(), 8'b0000_0000); end
        next();
    endtask

    task automatic test_mem_wait();
        do_reset();
        in_a = lw(5'd0, 5'd8);          next();
        in_a = alu(5'd1, 5'd2, 5'd10);  next();
        in_a  = alu(5'd10, 5'd8, 5'd11);
        mio_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++;
            if (obs_a() !== 8'b1001_0111) begin failures++; $display("FAIL mw_freeze%0d got=%b exp=%b", k, obs_a(), 8'b1001_0111); end
            next();
        end
        mio_a = 1'b1;
        settle();
        checks++;
        if (obs_a() !== 8'b0000_0111) begin failures++; $display("FAIL mw_release got=%b exp=%b", obs_a(), 8'b0000_0111); end
        checks++;
        if (dut_a.state_q !== ST_MEM_WAIT) begin failures++; $display("FAIL mw_state_wait got=%0d exp=%0d", dut_a.state_q, ST_MEM_WAIT); end
        next();
        in_a = '0;
        settle();
        checks++;
        if (dut_a.state_q !== ST_RUN) begin failures++; $display("FAIL mw_state_run got=%0d exp=%0d", dut_a.state_q, ST_RUN); end
        checks++;
        if ({ifa.mem_timeout, ifa.stall_count} !== {1'b0, 16'd3}) begin
            failures++; $display("FAIL mw_regs got=%0d/%0d exp=0/3", ifa.mem_timeout, ifa.stall_count);
        end
        next();
    endtask

    task automatic test_timeout_reset();
        do_reset();
        in_a = lw(5'd0, 5'd8);  next();
        in_a = '0;              next();
        mio_a = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            checks++;
            if ({ifa.freeze, ifa.mem_timeout} !== 2'b10) begin
                failures++; $display("FAIL to_wait%0d got=%b exp=%b", k, {ifa.freeze, ifa.mem_timeout}, 2'b10);
            end
            next();
        end
        settle();
        checks++;
        if ({ifa.freeze, ifa.mem_timeout} !== 2'b11) begin
            failures++; $display("FAIL to_set got=%b exp=%b", {ifa.freeze, ifa.mem_timeout}, 2'b11);
        end
        checks++;
        if (ifa.stall_count !== 16'd5) begin failures++; $display("FAIL to_count got=%0d exp=5", ifa.stall_count); end
        next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        settle();
        checks++;
        if (obs_a() !== 8'b0) begin failures++; $display("FAIL to_rst_outs got=%b exp=%b", obs_a(), 8'b0); end
        checks++;
        if ({ifa.mem_timeout, ifa.stall_count} !== 17'd0) begin
            failures++; $display("FAIL to_rst_regs got=%0d/%0d exp=0/0", ifa.mem_timeout, ifa.stall_count);
        end
        checks++;
        if (dut_a.state_q !== ST_RUN) begin failures++; $display("FAIL to_rst_state got=%0d exp=%0d", dut_a.state_q, ST_RUN); end
        next();
        in_a = alu(5'd8, 5'd8, 5'd9);
        settle();
        checks++;
        if (obs_a() !== 8'b0) begin failures++; $display("FAIL to_rst_sb got=%b exp=%b", obs_a(), 8'b0); end
        mio_a = 1'b1;
        next();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        in_a = lw(5'd0, 5'd8);  next();
        in_a = alu(5'd8, 5'd8, 5'd9);  settle();
        checks++;
        if (obs_a() !== 8'b1100_0000) begin failures++; $display("FAIL rs_stall got=%b exp=%b", obs_a(), 8'b1100_0000); end
        rst = 1'b1;
        next();
        rst = 1'b0;
        settle();
        checks++;
        if (obs_a() !== 8'b0) begin failures++; $display("FAIL rs_after got=%b exp=%b", obs_a(), 8'b0); end
        checks++;
        if (ifa.stall_count !== 16'd0) begin failures++; $display("FAIL rs_count got=%0d exp=0", ifa.stall_count); end
        next();
    endtask

    task automatic test_stall_only();
        do_reset();
        in_b = alu(5'd1, 5'd2, 5'd3);  next();
        in_b = alu(5'd1, 5'd2, 5'd4);  next();
        in_b = alu(5'd1, 5'd2, 5'd5);  next();
        in_b = alu(5'd3, 5'd7, 5'd6);  settle();
        checks++;
        if (obs_b() !== 8'b1100_0000) begin failures++; $display("FAIL so_wb_stall got=%b exp=%b", obs_b(), 8'b1100_0000); end
        next();
        settle();
        checks++;
        if (obs_b() !== 8'b0000_0000) begin failures++; $display("FAIL so_wb_retired got=%b exp=%b", obs_b(), 8'b0000_0000); end
        next();
        in_b = '0;
        repeat (3) next();
        in_b = alu(5'd1, 5'd2, 5'd3);  next();
        in_b = alu(5'd3, 5'd7, 5'd6);
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++;
            if (obs_b() !== 8'b1100_0000) begin failures++; $display("FAIL so_ex_stall%0d got=%b exp=%b", k, obs_b(), 8'b1100_0000); end
            next();
        end
        settle();
        checks++;
        if (obs_b() !== 8'b0000_0000) begin failures++; $display("FAIL so_ex_go got=%b exp=%b", obs_b(), 8'b0000_0000); end
        checks++;
        if (ifb.stall_count !== 16'd4) begin failures++; $display("FAIL so_count got=%0d exp=4", ifb.stall_count); end
        next();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_reg_zero();
        test_mem_wait();
        test_timeout_reset();
        test_reset_mid_stall();
        test_stall_only();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Parametrised successor to the ID-stage control/hazard logic of the 5-stage MIPS pipeline.
- Keeps a scoreboard of in-flight register writes (EX, MEM, WB, ...).
- Produces forwarding selects, load-use and branch-operand stalls, branch flushes, and a full-pipeline freeze while memory (MIO) is not ready.
- Adds a stall-only mode, a memory-wait FSM with timeout and a stall performance counter.

Parameters:
- REG_AW, 5, register address width.
- DEPTH, 3, scoreboard entries tracked past ID (0=EX, 1=MEM, 2..=WB and later); legal range 2..8.
- FWD_EN, 1, 1 = forwarding enabled; 0 = stall on any scoreboard match.
- WAIT_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before mem_timeout is set.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_AW  ID source register rs.
- id_rt  in  REG_AW  ID source register rt.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_wr_en  in  1  instruction writes the register file.
- id_wr_addr  in  REG_AW  destination register (rt/rd/31 already resolved).
- id_is_load  in  1  instruction is lw.
- id_is_mem  in  1  instruction is lw or sw.
- id_is_branch  in  1  instruction is beq, bne or jr (compares/reads in ID).
- id_branch_taken  in  1  redirect resolved this cycle (j/jal/jr/taken branch).
- mio_ready  in  1  memory ready.
- stall_if  out  1  hold PC and IF/ID.
- bubble_ex  out  1  insert NOP into ID/EX.
- flush_if  out  1  squash IF/ID contents.
- freeze  out  1  hold all pipeline registers.
- fwd_rs_sel  out  2  rs operand source: 0 regfile, 1 EX ALU, 2 MEM ALU, 3 MEM load data.
- fwd_rt_sel  out  2  rt operand source, same encoding.
- mem_timeout  out  1  sticky error.
- stall_count  out  CNT_W  cycles with stall_if or freeze asserted.

Behaviour:
- Clocking: clk only. Reset is synchronous and active-high.
- Reset: all scoreboard entries invalid, FSM in RUN, mem_timeout=0, stall_count=0. All combinational outputs evaluate to 0 after reset.
- Scoreboard entry: {valid, addr, is_load, is_mem}.
- Match rule: valid & addr==src & addr!=0 & use_src. Register $0 never matches.
- Forwarding (FWD_EN=1), youngest entry wins:
  - EX non-load match -> 1.
  - else MEM match -> 3 if load, else 2.
  - else 0. Entries at index >=2 rely on regfile write-before-read.
- Stall, FWD_EN=1:
  - Load-use: EX entry is a load and matches rs or rt.
  - Branch operand: id_is_branch and either the EX entry matches, or the MEM entry is a load that matches.
- Stall, FWD_EN=0: any entry at any index matches. fwd_*_sel are forced to 0.
- Stall response: stall_if=1 and bubble_ex=1. Scoreboard shifts with entry0 invalid.
- Freeze: freeze = (MEM entry valid & is_mem & !mio_ready). It is combinational, same cycle. When freeze=1:
  - scoreboard does not shift;
  - stall_if=1, bubble_ex=0, flush_if=0.
- Priority: freeze > stall > flush.
- flush_if: id_branch_taken & !stall & !freeze. A branch that is stalled resolves on a later cycle.
- Advance (no freeze): entry[i+1] <= entry[i]. entry0 <= ID dest only if id_valid & id_wr_en & !stall; otherwise invalid.
- Memory-wait FSM, states RUN and MEM_WAIT:
  - RUN -> MEM_WAIT when freeze=1.
  - MEM_WAIT -> RUN on the first cycle freeze=0.
  - A wait counter increments each MEM_WAIT cycle that freeze stays 1 and clears on return to RUN.
  - When the counter reaches WAIT_TIMEOUT, mem_timeout is set. It clears only on rst.
- stall_count increments on any cycle with stall_if=1 and saturates at all-ones.
- Reset asserted mid-wait or mid-stall: next cycle is RUN with an empty scoreboard. No stale forwarding.

Decomposition:
- Shared package pipeline_pkg:
  - REG_AW;
  - fwd_sel encodings FWD_REG/FWD_EX_ALU/FWD_MEM_ALU/FWD_MEM_LOAD;
  - FSM state enum ST_RUN/ST_MEM_WAIT;
  - scoreboard entry struct.
- One sub-module, hazard_scoreboard: the DEPTH-entry shift register with shift/insert/hold controls and per-entry match outputs for rs and rt.

Test Plan:
- Forwarding: add $3,$1,$2 then sub $4,$3,$5 (FWD_EN=1) -> fwd_rs_sel=1 in the sub's ID cycle, no stall. One instruction later the same dependency -> fwd_rs_sel=2.
- Load-use: lw $8,0($0) then add $9,$8,$8 -> one cycle with stall_if=1 and bubble_ex=1, then fwd_rs_sel=fwd_rt_sel=3. stall_count=1.
- Branch: beq $8,$0 directly after addi $8,... -> one stall cycle, then flush_if=1 on the resolve cycle.
- Branch: jr after lw $31 -> two stall cycles.
- Write to $0: add $0,$1,$2 then add $5,$0,$0 -> no stall, fwd selects 0.
- Memory wait: lw in MEM with mio_ready=0 for 3 cycles -> freeze=1 for exactly 3 cycles, scoreboard unchanged, FSM back in RUN on cycle 4.
- Timeout and reset: with WAIT_TIMEOUT=4, mio_ready held 0 -> mem_timeout=1 after 4 wait cycles. Then rst=1 mid-wait -> next cycle freeze=0, scoreboard empty, stall_count=0.
- Stall-only mode (FWD_EN=0): dependency on a WB-stage entry (index 2) -> stall_if=1 until it retires, fwd selects 0 throughout.
